// File: rtl/mem_copier_if.sv
// Bus between a mem_copier engine, its controller and the single-port data memory.
// Control is start/busy/done: start is taken only while idle, busy spans the copy, done pulses once on completion.
interface mem_copier_if #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 256,
    parameter int ADDR_WIDTH = $clog2(LENGTH)
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH:0]   count;
    logic                  busy;
    logic                  done;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wd;
    logic [WIDTH-1:0]      mem_rd;

    modport master (
        input  start, abort, src, dst, count, mem_rd,
        output busy, done, mem_wr_en, mem_rd_en, mem_addr, mem_wd
    );

    modport slave (
        output start, abort, src, dst, count, mem_rd,
        input  busy, done, mem_wr_en, mem_rd_en, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_copier.sv
// Simple DMA engine: copies count words from src to dst inside one single-port memory,
// one read cycle and one write cycle per word, ascending with modulo-LENGTH wrap.
module mem_copier #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 256,
    parameter int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_copier_if.master bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [WIDTH-1:0]      data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        src_ptr_d   = bus.src;
                        dst_ptr_d   = bus.dst;
                        remaining_d = bus.count;
                        state_d     = RD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    data_d    = bus.mem_rd;
                    src_ptr_d = src_ptr_q + ADDR_WIDTH'(1);
                    state_d   = WR;
                end
            end
            WR: begin
                // The write is already on the bus, so it lands even when aborting.
                dst_ptr_d   = dst_ptr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - CW'(1);
                if (bus.abort)                      state_d = IDLE;
                else if (remaining_q == CW'(1))     state_d = FIN;
                else                                state_d = RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so reset drops them immediately.
    assign bus.busy      = (state_q == RD) || (state_q == WR);
    assign bus.done      = (state_q == FIN);
    assign bus.mem_rd_en = (state_q == RD);
    assign bus.mem_wr_en = (state_q == WR);
    assign bus.mem_addr  = (state_q == RD) ? src_ptr_q :
                           (state_q == WR) ? dst_ptr_q : '0;
    assign bus.mem_wd    = data_q;
    assign dbg_state_o   = state_q;
endmodule
